// File: rtl/sw_step_ctrl.sv
// sw_step_ctrl: key front end for the LED rotator.
// It synchronizes and debounces two active-low push keys. It then turns the
// clean levels into one-cycle step pulses, with auto-repeat while a key is held.
module sw_step_ctrl #(
    parameter int DEB_CYCLES = 500000,
    parameter int RPT_DELAY  = 25000000,
    parameter int RPT_PERIOD = 5000000,
    parameter int CNT_W      = 25
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [1:0] iKey,
    output logic [1:0] oSW,
    output logic [1:0] oKeyState
);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(RPT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(RPT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DELAY  = 2'b01,
        ST_REPEAT = 2'b10,
        ST_LOCK   = 2'b11
    } state_t;

    logic [1:0]       key_meta_r;
    logic [1:0]       key_sync_r;
    logic [CNT_W-1:0] deb_cnt_r [2];
    logic [1:0]       stable_r;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [1:0]       dir_r;
    logic [1:0]       dir_nxt_s;
    logic [CNT_W-1:0] timer_r;
    logic [CNT_W-1:0] timer_nxt_s;
    logic [1:0]       sw_nxt_s;
    logic [1:0]       sw_r;

    logic             held_s;
    logic             other_s;

    // The latched direction key is still pressed; the opposite key is pressed.
    assign held_s  = |(stable_r & dir_r);
    assign other_s = |(stable_r & ~dir_r);

    // Two-flop synchronizer; inversion makes 1 mean pressed, reset means released.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            key_meta_r <= 2'b00;
            key_sync_r <= 2'b00;
        end else begin
            key_meta_r <= ~iKey;
            key_sync_r <= key_meta_r;
        end
    end

    // Per-key debounce: a new level is accepted after DEB_CYCLES consecutive cycles.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int i = 0; i < 2; i++) begin
                deb_cnt_r[i] <= CNT_ZERO;
            end
            stable_r <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (key_sync_r[i] == stable_r[i]) begin
                    deb_cnt_r[i] <= CNT_ZERO;
                end else if (deb_cnt_r[i] == DEB_LAST) begin
                    stable_r[i]  <= key_sync_r[i];
                    deb_cnt_r[i] <= CNT_ZERO;
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + CNT_ONE;
                end
            end
        end
    end

    // Step FSM state, latched direction and repeat timer.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_r <= ST_IDLE;
            dir_r   <= 2'b00;
            timer_r <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            dir_r   <= dir_nxt_s;
            timer_r <= timer_nxt_s;
        end
    end

    // Next-state logic; a release beats a lock, and a lock beats a timer expiry.
    always_comb begin
        state_nxt_s = state_r;
        dir_nxt_s   = dir_r;
        timer_nxt_s = timer_r;
        case (state_r)
            ST_IDLE: begin
                timer_nxt_s = CNT_ZERO;
                case (stable_r)
                    2'b01: begin
                        state_nxt_s = ST_DELAY;
                        dir_nxt_s   = 2'b01;
                    end
                    2'b10: begin
                        state_nxt_s = ST_DELAY;
                        dir_nxt_s   = 2'b10;
                    end
                    2'b11: begin
                        state_nxt_s = ST_LOCK;
                    end
                    default: begin
                        state_nxt_s = ST_IDLE;
                    end
                endcase
            end
            ST_DELAY: begin
                if (!held_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (other_s) begin
                    state_nxt_s = ST_LOCK;
                end else if (timer_r == DLY_LAST) begin
                    state_nxt_s = ST_REPEAT;
                    timer_nxt_s = CNT_ZERO;
                end else begin
                    timer_nxt_s = timer_r + CNT_ONE;
                end
            end
            ST_REPEAT: begin
                if (!held_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (other_s) begin
                    state_nxt_s = ST_LOCK;
                end else if (timer_r == PER_LAST) begin
                    timer_nxt_s = CNT_ZERO;
                end else begin
                    timer_nxt_s = timer_r + CNT_ONE;
                end
            end
            ST_LOCK: begin
                timer_nxt_s = CNT_ZERO;
                if (stable_r == 2'b00) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_LOCK;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                dir_nxt_s   = 2'b00;
                timer_nxt_s = CNT_ZERO;
            end
        endcase
    end

    // Pulse decode; this uses the same priorities as the next-state logic.
    always_comb begin
        sw_nxt_s = 2'b00;
        case (state_r)
            ST_IDLE: begin
                if (stable_r == 2'b01 || stable_r == 2'b10) begin
                    sw_nxt_s = stable_r;
                end else begin
                    sw_nxt_s = 2'b00;
                end
            end
            ST_DELAY: begin
                if (held_s && !other_s && timer_r == DLY_LAST) begin
                    sw_nxt_s = dir_r;
                end else begin
                    sw_nxt_s = 2'b00;
                end
            end
            ST_REPEAT: begin
                if (held_s && !other_s && timer_r == PER_LAST) begin
                    sw_nxt_s = dir_r;
                end else begin
                    sw_nxt_s = 2'b00;
                end
            end
            default: begin
                sw_nxt_s = 2'b00;
            end
        endcase
    end

    // Registered step output; reset also drops any pulse in flight.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            sw_r <= 2'b00;
        end else begin
            sw_r <= sw_nxt_s;
        end
    end

    assign oSW       = sw_r;
    assign oKeyState = stable_r;

endmodule

// File: tb/tb_sw_step_ctrl.sv
// Scoreboard bench for sw_step_ctrl with short debounce and repeat timings.
module tb_sw_step_ctrl;

    logic       iClk = 1'b0;
    logic       iRst;
    logic [1:0] iKey;
    logic [1:0] oSW;
    logic [1:0] oKeyState;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         cyc;
        logic [1:0] val;
    } exp_t;

    exp_t       exp_q [$];
    logic [1:0] prev_sw = 2'b00;

    sw_step_ctrl #(
        .DEB_CYCLES(4),
        .RPT_DELAY (20),
        .RPT_PERIOD(8),
        .CNT_W     (8)
    ) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iKey     (iKey),
        .oSW      (oSW),
        .oKeyState(oKeyState)
    );

    always #5 iClk = ~iClk;

    // Count rising edges; edge N is the Nth posedge since time zero.
    always @(posedge iClk) cyc <= cyc + 1;

    // Monitor: every pulse must match the next expected pulse (edge and value).
    always @(negedge iClk) begin
        if (oSW != 2'b00) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse edge=%0d actual=%b required=none", cyc, oSW);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.val != oSW) begin
                    errors++;
                    $display("FAIL pulse actual edge=%0d val=%b required edge=%0d val=%b",
                             cyc, oSW, e.cyc, e.val);
                end
            end
            if (prev_sw != 2'b00) begin
                checks++;
                errors++;
                $display("FAIL back_to_back edge=%0d actual=%b previous=%b", cyc, oSW, prev_sw);
            end
        end
        prev_sw = oSW;
    end

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic expect_pulse(input int at, input logic [1:0] val);
        exp_t e;
        e.cyc = at;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge iClk);
    endtask

    task automatic chk_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s missing_pulses actual=%0d required=0 next_edge=%0d",
                     name, exp_q.size(), exp_q[0].cyc);
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int rel;
        iRst = 1'b1;
        iKey = 2'b11;
        repeat (3) @(negedge iClk);
        chk("reset_sw", oSW, 2'b00);
        chk("reset_keystate", oKeyState, 2'b00);
        iRst = 1'b0;
        repeat (10) @(negedge iClk);
        chk("idle_keystate", oKeyState, 2'b00);

        // 1: clean single press of the right key
        base = cyc;
        iKey = 2'b10;
        expect_pulse(base + 7, 2'b01);
        wait_until(base + 5);
        chk("t1_ks_edge5", oKeyState, 2'b00);
        wait_until(base + 6);
        chk("t1_ks_edge6", oKeyState, 2'b01);
        wait_until(base + 10);
        iKey = 2'b11;
        rel = cyc;
        wait_until(rel + 5);
        chk("t1_ks_rel5", oKeyState, 2'b01);
        wait_until(rel + 6);
        chk("t1_ks_rel6", oKeyState, 2'b00);
        wait_until(rel + 30);
        chk_drained("t1");

        // 2: bouncing left key, then a steady press
        for (int i = 0; i < 3; i++) begin
            iKey = 2'b01;
            repeat (2) @(negedge iClk);
            iKey = 2'b11;
            repeat (2) @(negedge iClk);
        end
        chk("t2_ks_bounce", oKeyState, 2'b00);
        base = cyc;
        iKey = 2'b01;
        expect_pulse(base + 7, 2'b10);
        wait_until(base + 6);
        chk("t2_ks_edge6", oKeyState, 2'b10);
        wait_until(base + 10);
        iKey = 2'b11;
        wait_until(base + 30);
        chk_drained("t2");

        // 3: long hold of the right key with auto-repeat
        base = cyc;
        iKey = 2'b10;
        expect_pulse(base + 7,  2'b01);
        expect_pulse(base + 27, 2'b01);
        expect_pulse(base + 35, 2'b01);
        expect_pulse(base + 43, 2'b01);
        expect_pulse(base + 51, 2'b01);
        expect_pulse(base + 59, 2'b01);
        wait_until(base + 60);
        iKey = 2'b11;
        wait_until(base + 90);
        chk_drained("t3");
        chk("t3_ks_released", oKeyState, 2'b00);

        // 4: second key joins during the delay, so the FSM locks
        base = cyc;
        iKey = 2'b10;
        expect_pulse(base + 7, 2'b01);
        wait_until(base + 15);
        iKey = 2'b00;
        wait_until(base + 22);
        chk("t4_ks_both", oKeyState, 2'b11);
        wait_until(base + 40);
        iKey = 2'b11;
        wait_until(base + 50);
        chk_drained("t4_lock");
        base = cyc;
        iKey = 2'b01;
        expect_pulse(base + 7, 2'b10);
        wait_until(base + 10);
        iKey = 2'b11;
        wait_until(base + 30);
        chk_drained("t4_after");

        // 5: both keys pressed together
        base = cyc;
        iKey = 2'b00;
        wait_until(base + 6);
        chk("t5_ks_both", oKeyState, 2'b11);
        wait_until(base + 20);
        iKey = 2'b11;
        wait_until(base + 40);
        chk("t5_ks_released", oKeyState, 2'b00);

        // 6: reset in the middle of auto-repeat with the key still held
        base = cyc;
        iKey = 2'b10;
        expect_pulse(base + 7,  2'b01);
        expect_pulse(base + 27, 2'b01);
        wait_until(base + 30);
        iRst = 1'b1;
        #1;
        chk("t6_rst_sw", oSW, 2'b00);
        chk("t6_rst_ks", oKeyState, 2'b00);
        chk_drained("t6_before_reset");
        wait_until(base + 33);
        iRst = 1'b0;
        rel = cyc;
        expect_pulse(rel + 7,  2'b01);
        expect_pulse(rel + 27, 2'b01);
        wait_until(rel + 28);
        iKey = 2'b11;
        wait_until(rel + 60);
        chk_drained("t6_after_reset");
        chk("t6_ks_released", oKeyState, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
